addsub_accumulator: RTL
=======================

# addsub_accumulator

Sequential accumulator controller that sits directly upstream of the 4-bit ripple adder/subtractor and consumes its result. It accepts one command at a time over a valid/ready handshake and drives the adder's A, B and Sub inputs. It registers the adder's Sum and Cout into an accumulator with status flags. Multiply is implemented as repeated addition through the same adder, so it is multi-cycle.

## Interface
- WIDTH, 4, data width; must match the adder width.
- Clk  in  1  clock, rising edge.
- Rst_n  in  1  reset, asynchronous, active-low.
- In_Valid  in  1  command valid.
- In_Ready  out  1  block can accept a command; high exactly when the FSM is in IDLE.
- Op  in  3  command code.
  - 0 CLR, 1 LOAD, 2 ADD, 3 SUB, 4 MUL, 5 NEG.
  - 6 and 7 are illegal.
- Operand  in  WIDTH  command operand.
- Adder_A  out  WIDTH  adder A input.
- Adder_B  out  WIDTH  adder B input; un-inverted, because the adder applies Sub internally.
- Adder_Sub  out  1  adder subtract select.
- Adder_Sum  in  WIDTH  adder sum, combinational.
- Adder_Cout  in  1  adder carry-out; this is the carry for add and the borrow for subtract.
- Acc  out  WIDTH  accumulator.
- Carry  out  1  carry/borrow of the last completed command.
- Zero  out  1  Acc == 0.
- Ovf  out  1  overflow of the last completed command.
- Done  out  1  one-cycle completion pulse.

## Operation
- Handshake: a command is accepted on a rising edge where In_Valid && In_Ready. While In_Valid is high and not yet accepted, Op and Operand are held stable. In_Ready is combinational from the state only and never depends on In_Valid.
- FSM states: IDLE and MUL_RUN.
  - IDLE goes to MUL_RUN on accepting MUL.
  - Every other accepted op completes at the accept edge, and the FSM stays in IDLE.
  - MUL_RUN returns to IDLE on the edge where Cnt == 0.
- Adder drive:
  - IDLE: A=Acc, B=Operand, Sub=(Op==SUB).
  - IDLE with Op==NEG: A=0, B=Acc, Sub=1.
  - MUL_RUN: A=P, B=M, Sub=0.
  - Otherwise: A=Acc, B=Operand, Sub=0.
- Per-command effect at completion:
  - CLR: Acc=0; Carry=0; Ovf=0.
  - LOAD: Acc=Operand; Carry=0; Ovf=0.
  - ADD and SUB: Acc=Adder_Sum; Carry=Adder_Cout.
    - Ovf is signed overflow: (A[W-1]==Bx[W-1]) && (Sum[W-1]!=A[W-1]), where Bx = B ^ {W{Sub}}.
  - NEG: same rule as SUB, computed as 0 − Acc.
  - MUL (result is Acc × Operand, truncated to WIDTH):
    - At the accept edge: M=Acc, Cnt=Operand, P=0, Sticky=0.
    - Each MUL_RUN edge with Cnt != 0: P=Adder_Sum; Sticky |= Adder_Cout; Cnt decrements.
    - Edge with Cnt == 0: Acc=P; Carry=Ovf=Sticky.
  - Illegal op: Acc, Carry and Ovf are unchanged; Done still pulses.
- Zero is recomputed from the new Acc at every completion.
- Arithmetic is modulo 2^WIDTH. Cnt, M and P are WIDTH bits wide.

## Timing
- Reset values (asserted asynchronously on Rst_n low):
  - Acc=0, Carry=0, Ovf=0, Zero=1, Done=0.
  - FSM=IDLE, so In_Ready=1.
  - Internal P, M, Cnt and Sticky are all 0.
- Single-cycle ops: the result is on Acc and the flags, and Done=1, in the cycle immediately after the accept edge. In_Ready stays 1, so back-to-back commands keep Done high on consecutive cycles.
- MUL with Operand=N: In_Ready=0 for N+1 cycles after the accept edge. Acc, the flags and Done=1 appear N+1 cycles after the accept edge.
- MUL with N=0 takes 1 cycle and yields Acc=0, Carry=Ovf=0.
- Acc and the flags hold their value during MUL_RUN and update only at completion.
- Done is high for exactly one cycle per completed command.
- Reset mid-MUL discards the partial product. Every output takes its reset value immediately, with no clock required.
- In_Valid low in IDLE: nothing changes; Done=0 the next cycle.

## Test plan
- Reset: drive Rst_n low with no Clk edge → Acc=0, Zero=1, Carry=0, Ovf=0, Done=0, In_Ready=1.
- Add:
  - LOAD 7 then ADD 9 → Acc=0, Carry=1, Zero=1, Ovf=0.
  - LOAD 4 then ADD 4 → Acc=8, Carry=0, Ovf=1.
- Subtract and negate:
  - LOAD 3 then SUB 5 → Acc=14, Carry(borrow)=1, Ovf=0.
  - LOAD 8 then SUB 1 → Acc=7, Carry=0, Ovf=1.
  - LOAD 8 then NEG → Acc=8, Ovf=1.
- Multiply:
  - LOAD 3 then MUL 5 → In_Ready low for 6 cycles, then Acc=15, Carry=Ovf=0, one Done pulse.
  - LOAD 5 then MUL 4 → Acc=4, Carry=Ovf=1.
  - MUL 0 → Acc=0 after 1 cycle.
- Handshake and illegal op:
  - Hold In_Valid with Op=ADD during MUL_RUN → not accepted until In_Ready returns, then executes exactly once.
  - Op=6 → Acc unchanged, Done pulses once.
- Reset mid-MUL: LOAD 2, MUL 15, drop Rst_n 3 cycles into MUL_RUN → Acc=0 and In_Ready=1 immediately. Then LOAD 2, MUL 3 → Acc=6.

Source files
------------

// File: rtl/addsub_accumulator.sv
// addsub_accumulator: command-driven accumulator controller that sits in front of an
// external ripple adder/subtractor. Single-cycle commands are CLR, LOAD, ADD, SUB and NEG.
// MUL is done by repeated addition through the same adder, so it takes several cycles.
module addsub_accumulator #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_operand,
  output logic [WIDTH-1:0] o_adder_a,
  output logic [WIDTH-1:0] o_adder_b,
  output logic             o_adder_sub,
  input  logic [WIDTH-1:0] i_adder_sum,
  input  logic             i_adder_cout,
  output logic [WIDTH-1:0] o_acc,
  output logic             o_carry,
  output logic             o_zero,
  output logic             o_ovf,
  output logic             o_done
);

  localparam logic [2:0] OP_CLR  = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_MUL  = 3'd4;
  localparam logic [2:0] OP_NEG  = 3'd5;

  typedef enum logic {
    ST_IDLE,
    ST_MUL_RUN
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic             r_ovf;
  logic             r_done;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_cnt;
  logic             r_sticky;

  logic             w_accept;
  logic             w_cnt_zero;
  logic [WIDTH-1:0] w_bx;
  logic             w_ovf;

  assign w_accept   = i_in_valid && o_in_ready;
  assign w_cnt_zero = (r_cnt == '0);

  // The adder sees B un-inverted; rebuild the effective second operand for the overflow rule.
  assign w_bx  = o_adder_b ^ {WIDTH{o_adder_sub}};
  assign w_ovf = (o_adder_a[WIDTH-1] == w_bx[WIDTH-1]) &&
                 (i_adder_sum[WIDTH-1] != o_adder_a[WIDTH-1]);

  assign o_acc   = r_acc;
  assign o_carry = r_carry;
  assign o_ovf   = r_ovf;
  assign o_done  = r_done;
  // Acc only changes at a completion, so deriving Zero from it is the same as recomputing there.
  assign o_zero  = (r_acc == '0);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic, ready, and adder operand steering.
  always_comb begin
    w_state_next = r_state;
    o_in_ready   = 1'b0;
    o_adder_a    = r_acc;
    o_adder_b    = i_operand;
    o_adder_sub  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_in_ready = 1'b1;
        if (i_op == OP_NEG) begin
          // Negate as 0 - Acc so the adder's borrow and overflow rules apply unchanged.
          o_adder_a   = '0;
          o_adder_b   = r_acc;
          o_adder_sub = 1'b1;
        end else begin
          o_adder_sub = (i_op == OP_SUB);
        end
        if (w_accept && (i_op == OP_MUL)) begin
          w_state_next = ST_MUL_RUN;
        end
      end
      ST_MUL_RUN: begin
        o_adder_a = r_p;
        o_adder_b = r_m;
        if (w_cnt_zero) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Accumulator, flags, done pulse and multiply working registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc    <= '0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
      r_p      <= '0;
      r_m      <= '0;
      r_cnt    <= '0;
      r_sticky <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (w_accept) begin
          // Everything except MUL completes on the accept edge, illegal codes included.
          r_done <= (i_op != OP_MUL);
          case (i_op)
            OP_CLR: begin
              r_acc   <= '0;
              r_carry <= 1'b0;
              r_ovf   <= 1'b0;
            end
            OP_LOAD: begin
              r_acc   <= i_operand;
              r_carry <= 1'b0;
              r_ovf   <= 1'b0;
            end
            OP_ADD, OP_SUB, OP_NEG: begin
              r_acc   <= i_adder_sum;
              r_carry <= i_adder_cout;
              r_ovf   <= w_ovf;
            end
            OP_MUL: begin
              r_m      <= r_acc;
              r_cnt    <= i_operand;
              r_p      <= '0;
              r_sticky <= 1'b0;
            end
            default: begin
              // Illegal op: state is left untouched, only Done pulses.
            end
          endcase
        end
      end else begin
        if (!w_cnt_zero) begin
          // One partial addition per cycle; any carry out means the product wrapped.
          r_p      <= i_adder_sum;
          r_sticky <= r_sticky | i_adder_cout;
          r_cnt    <= r_cnt - 1'b1;
        end else begin
          r_acc   <= r_p;
          r_carry <= r_sticky;
          r_ovf   <= r_sticky;
          r_done  <= 1'b1;
        end
      end
    end
  end

endmodule
